// File: rtl/ip_msxbus_master_if.sv
// MSX 50-pin cartridge bus pins seen from the host side: address, data, selects, strobes and /WAIT.
// The master drives the address, selects and strobes; the addressed target returns i_data and n_wait.
interface ip_msxbus_master_if;

  logic [15:0] adr;
  logic [7:0]  o_data;
  logic        data_oe;
  logic [7:0]  i_data;
  logic        n_sltsl;
  logic        n_mereq;
  logic        n_ioreq;
  logic        n_rd;
  logic        n_wr;
  logic        n_wait;

  modport master (
    output adr, o_data, data_oe, n_sltsl, n_mereq, n_ioreq, n_rd, n_wr,
    input  i_data, n_wait
  );

  modport slave (
    input  adr, o_data, data_oe, n_sltsl, n_mereq, n_ioreq, n_rd, n_wr,
    output i_data, n_wait
  );

endinterface

// File: rtl/ip_msxbus_master.sv
// Z80-style MSX bus initiator: turns one-clk rd/wr requests into T1/T2/TW/T3 memory or I/O cycles.
// Define MSXBUS_MASTER_TIMEOUT_EN to abort after WAIT_TIMEOUT_TSTATES wait states (rdata=0xFF, timeout pulse).
module ip_msxbus_master #(
  parameter int T_STATE_CLKS         = 15,
  parameter int WAIT_TIMEOUT_TSTATES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic        io,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        rdata_en,
  output logic        timeout,
  ip_msxbus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  localparam int CW = (T_STATE_CLKS > 1) ? $clog2(T_STATE_CLKS) : 1;
  localparam logic [CW-1:0] TSTATE_LAST = CW'(T_STATE_CLKS - 1);

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          is_read;
  logic          is_io;
  logic          wait_meta;
  logic          wait_sync;

`ifdef MSXBUS_MASTER_TIMEOUT_EN
  localparam int TWW = $clog2(WAIT_TIMEOUT_TSTATES + 1);
  localparam logic [TWW-1:0] TW_LIMIT = TWW'(WAIT_TIMEOUT_TSTATES);
  logic [TWW-1:0] tw_cnt;
  logic           timed_out;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (WAIT_TIMEOUT_TSTATES != 0);
  assign timeout = 1'b0;
`endif

  // /WAIT comes from the target asynchronously; idle state is "not waiting".
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_meta <= 1'b1;
      wait_sync <= 1'b1;
    end else begin
      wait_meta <= bus.n_wait;
      wait_sync <= wait_meta;
    end
  end

  // Every bus pin is registered here; strobes change only on T-state boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      is_read     <= 1'b0;
      is_io       <= 1'b0;
      busy        <= 1'b0;
      rdata       <= 8'h00;
      rdata_en    <= 1'b0;
      bus.adr     <= 16'h0000;
      bus.o_data  <= 8'h00;
      bus.data_oe <= 1'b0;
      bus.n_sltsl <= 1'b1;
      bus.n_mereq <= 1'b1;
      bus.n_ioreq <= 1'b1;
      bus.n_rd    <= 1'b1;
      bus.n_wr    <= 1'b1;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
      tw_cnt      <= '0;
      timed_out   <= 1'b0;
      timeout     <= 1'b0;
`endif
    end else begin
      rdata_en <= 1'b0;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      if (state == IDLE) begin
        if (rd || wr) begin
          state   <= T1;
          tcnt    <= '0;
          busy    <= 1'b1;
          is_read <= rd;
          is_io   <= io;
          bus.adr <= address;
          if (!rd) begin
            bus.o_data  <= wdata;
            bus.data_oe <= 1'b1;
          end
`ifdef MSXBUS_MASTER_TIMEOUT_EN
          tw_cnt    <= '0;
          timed_out <= 1'b0;
`endif
        end
      end else if (tcnt != TSTATE_LAST) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
        case (state)
          T1: begin
            state       <= T2;
            bus.n_sltsl <= is_io;
            bus.n_mereq <= is_io;
            bus.n_ioreq <= !is_io;
            bus.n_rd    <= !is_read;
            bus.n_wr    <= is_read;
          end
          // The I/O forced wait state does not count towards the abort limit.
          T2: begin
            if (is_io) begin
              state <= TW;
            end else if (!wait_sync) begin
              state <= TW;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
              tw_cnt <= tw_cnt + 1'b1;
`endif
            end else begin
              state <= T3;
            end
          end
          TW: begin
            if (!wait_sync) begin
`ifdef MSXBUS_MASTER_TIMEOUT_EN
              if (tw_cnt == TW_LIMIT) begin
                state     <= T3;
                timed_out <= 1'b1;
              end else begin
                state  <= TW;
                tw_cnt <= tw_cnt + 1'b1;
              end
`else
              state <= TW;
`endif
            end else begin
              state <= T3;
            end
          end
          T3: begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.data_oe <= 1'b0;
            bus.n_sltsl <= 1'b1;
            bus.n_mereq <= 1'b1;
            bus.n_ioreq <= 1'b1;
            bus.n_rd    <= 1'b1;
            bus.n_wr    <= 1'b1;
            if (is_read) begin
              rdata_en <= 1'b1;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
              rdata    <= timed_out ? 8'hFF : bus.i_data;
`else
              rdata    <= bus.i_data;
`endif
            end
`ifdef MSXBUS_MASTER_TIMEOUT_EN
            timeout <= timed_out;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_msxbus_master.sv
// Directed bench for ip_msxbus_master: memory/I/O reads and writes, /WAIT stretching, reset abort, request filtering.
// The abort test is built only when MSXBUS_MASTER_TIMEOUT_EN is defined (limit overridden to 4).
module tb_ip_msxbus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, io;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        timeout;

  ip_msxbus_master_if bus ();

  ip_msxbus_master #(
    .T_STATE_CLKS(15),
    .WAIT_TIMEOUT_TSTATES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd(rd),
    .wr(wr),
    .io(io),
    .address(address),
    .wdata(wdata),
    .busy(busy),
    .rdata(rdata),
    .rdata_en(rdata_en),
    .timeout(timeout),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int busyClks, sltslLow, mereqLow, ioreqLow, rdLow, wrLow, oeHigh, enCnt, toCnt;
  logic enAtFall, toAtFall, cycleDone;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request at the current negedge and samples the bus every negedge until busy drops.
  // waitClks: 0 = no wait, >0 = hold n_wait low that many clks from T2 start, <0 = hold forever.
  task automatic applyStimulus(input logic isRd, input logic isWr, input logic isIo,
                               input logic [15:0] addr, input logic [7:0] wd,
                               input logic [7:0] target, input int waitClks, input int pokeAt);
    bit seenT2 = 0;
    int waitCnt = 0;
    rd = isRd; wr = isWr; io = isIo; address = addr; wdata = wd;
    bus.i_data = target;
    busyClks = 0; sltslLow = 0; mereqLow = 0; ioreqLow = 0; rdLow = 0; wrLow = 0;
    oeHigh = 0; enCnt = 0; toCnt = 0; enAtFall = 0; toAtFall = 0; cycleDone = 0;
    @(negedge clk);
    rd = 0; wr = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k == pokeAt) begin
        rd = 1; address = 16'h1234;
      end else if (k == pokeAt + 1) begin
        rd = 0;
      end
      if (!seenT2 && (bus.n_mereq == 1'b0 || bus.n_ioreq == 1'b0)) begin
        seenT2 = 1;
        if (waitClks != 0) bus.n_wait = 1'b0;
      end else if (seenT2 && bus.n_wait == 1'b0 && waitClks > 0) begin
        waitCnt++;
        if (waitCnt == waitClks) bus.n_wait = 1'b1;
      end
      if (busy) busyClks++;
      if (!bus.n_sltsl) sltslLow++;
      if (!bus.n_mereq) mereqLow++;
      if (!bus.n_ioreq) ioreqLow++;
      if (!bus.n_rd) rdLow++;
      if (!bus.n_wr) wrLow++;
      if (bus.data_oe) oeHigh++;
      if (rdata_en) enCnt++;
      if (timeout) toCnt++;
      if (!busy) begin
        cycleDone = 1;
        enAtFall = rdata_en;
        toAtFall = timeout;
        break;
      end
      @(negedge clk);
    end
    bus.n_wait = 1'b1;
    checkOutput("cycle_done", 32'(cycleDone), 32'd1);
  endtask

  task automatic checkStrobesHigh(input string tag);
    checkOutput(tag, {27'd0, bus.n_sltsl, bus.n_mereq, bus.n_ioreq, bus.n_rd, bus.n_wr}, 32'h1F);
  endtask

  initial begin
    reset = 1; rd = 0; wr = 0; io = 0; address = 16'h0000; wdata = 8'h00;
    bus.i_data = 8'h00; bus.n_wait = 1'b1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'h00);
    checkOutput("rst_rdata_en", 32'(rdata_en), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_adr", 32'(bus.adr), 32'h0000);
    checkOutput("rst_o_data", 32'(bus.o_data), 32'h00);
    checkOutput("rst_data_oe", 32'(bus.data_oe), 32'd0);
    checkStrobesHigh("rst_strobes");

    // Memory read, no wait
    applyStimulus(1, 0, 0, 16'h4000, 8'h00, 8'hA5, 0, -10);
    checkOutput("mrd_busy", busyClks, 45);
    checkOutput("mrd_sltsl", sltslLow, 30);
    checkOutput("mrd_mereq", mereqLow, 30);
    checkOutput("mrd_ioreq", ioreqLow, 0);
    checkOutput("mrd_n_rd", rdLow, 30);
    checkOutput("mrd_n_wr", wrLow, 0);
    checkOutput("mrd_oe", oeHigh, 0);
    checkOutput("mrd_en_cnt", enCnt, 1);
    checkOutput("mrd_en_at_fall", 32'(enAtFall), 32'd1);
    checkOutput("mrd_to_cnt", toCnt, 0);
    checkOutput("mrd_rdata", 32'(rdata), 32'hA5);
    checkOutput("mrd_adr", 32'(bus.adr), 32'h4000);
    checkStrobesHigh("mrd_strobes_end");

    // Memory write, issued in the same clk busy fell
    applyStimulus(0, 1, 0, 16'h8001, 8'h3C, 8'h00, 0, -10);
    checkOutput("mwr_busy", busyClks, 45);
    checkOutput("mwr_mereq", mereqLow, 30);
    checkOutput("mwr_n_wr", wrLow, 30);
    checkOutput("mwr_n_rd", rdLow, 0);
    checkOutput("mwr_oe", oeHigh, 45);
    checkOutput("mwr_en_cnt", enCnt, 0);
    checkOutput("mwr_o_data", 32'(bus.o_data), 32'h3C);
    checkOutput("mwr_adr", 32'(bus.adr), 32'h8001);
    checkOutput("mwr_rdata_kept", 32'(rdata), 32'hA5);
    checkOutput("mwr_oe_end", 32'(bus.data_oe), 32'd0);

    // I/O read with its forced wait state
    applyStimulus(1, 0, 1, 16'h0001, 8'h00, 8'h7F, 0, -10);
    checkOutput("iord_busy", busyClks, 60);
    checkOutput("iord_ioreq", ioreqLow, 45);
    checkOutput("iord_sltsl", sltslLow, 0);
    checkOutput("iord_mereq", mereqLow, 0);
    checkOutput("iord_n_rd", rdLow, 45);
    checkOutput("iord_en_at_fall", 32'(enAtFall), 32'd1);
    checkOutput("iord_rdata", 32'(rdata), 32'h7F);

    // Memory read stretched by 40 clks of /WAIT: two TW states
    applyStimulus(1, 0, 0, 16'h2000, 8'h00, 8'h5A, 40, -10);
    checkOutput("wait_busy", busyClks, 75);
    checkOutput("wait_n_rd", rdLow, 60);
    checkOutput("wait_en_cnt", enCnt, 1);
    checkOutput("wait_rdata", 32'(rdata), 32'h5A);
    checkOutput("wait_to_cnt", toCnt, 0);

    // Reset in the middle of a write (20th clk, inside T2)
    @(negedge clk);
    wr = 1; io = 0; address = 16'h9000; wdata = 8'h11;
    @(negedge clk);
    wr = 0;
    repeat (18) @(negedge clk);
    checkOutput("rstmid_n_wr_before", 32'(bus.n_wr), 32'd0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checkStrobesHigh("rstmid_strobes");
    checkOutput("rstmid_oe", 32'(bus.data_oe), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_en", 32'(rdata_en), 32'd0);

    // rd and wr together right after reset: read wins
    applyStimulus(1, 1, 0, 16'h4321, 8'hEE, 8'hC3, 0, -10);
    checkOutput("rdwr_busy", busyClks, 45);
    checkOutput("rdwr_n_rd", rdLow, 30);
    checkOutput("rdwr_n_wr", wrLow, 0);
    checkOutput("rdwr_oe", oeHigh, 0);
    checkOutput("rdwr_rdata", 32'(rdata), 32'hC3);
    checkOutput("rdwr_en_at_fall", 32'(enAtFall), 32'd1);

    // A second rd while busy is dropped
    applyStimulus(1, 0, 0, 16'h5555, 8'h00, 8'h66, 0, 5);
    checkOutput("poke_busy", busyClks, 45);
    checkOutput("poke_adr", 32'(bus.adr), 32'h5555);
    checkOutput("poke_rdata", 32'(rdata), 32'h66);
    @(negedge clk);
    checkOutput("poke_idle_after", 32'(busy), 32'd0);
    checkOutput("poke_en_after", 32'(rdata_en), 32'd0);

`ifdef MSXBUS_MASTER_TIMEOUT_EN
    // /WAIT never released: abort after 4 TW states
    applyStimulus(1, 0, 0, 16'h6000, 8'h00, 8'h99, -1, -10);
    checkOutput("to_busy", busyClks, 105);
    checkOutput("to_n_rd", rdLow, 90);
    checkOutput("to_rdata", 32'(rdata), 32'hFF);
    checkOutput("to_en_at_fall", 32'(enAtFall), 32'd1);
    checkOutput("to_at_fall", 32'(toAtFall), 32'd1);
    checkOutput("to_cnt", toCnt, 1);
    @(negedge clk);
    checkOutput("to_pulse_end", 32'(timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
